// File: rtl/snake_collision_checker.sv
// Post-move collision scan: wall and head-to-head tests at start, then one body index per cycle.
// Fixed MAX_LEN-cycle latency; start is ignored while busy, and the inputs must stay stable until done.
module snake_collision_checker #(
  parameter int GRID_W  = 160,
  parameter int GRID_H  = 120,
  parameter int MAX_LEN = 64
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] snake_1_x [MAX_LEN-1:0],
  input  logic [6:0] snake_1_y [MAX_LEN-1:0],
  input  logic [7:0] snake_2_x [MAX_LEN-1:0],
  input  logic [6:0] snake_2_y [MAX_LEN-1:0],
  input  logic [5:0] snake_1_size,
  input  logic [5:0] snake_2_size,
  output logic       busy,
  output logic       done,
  output logic       respawn_1,
  output logic       respawn_2,
  output logic [1:0] cause_1,
  output logic [1:0] cause_2
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(MAX_LEN - 1);

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_WALL  = 2'd1;
  localparam logic [1:0] CAUSE_SELF  = 2'd2;
  localparam logic [1:0] CAUSE_OTHER = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_REPORT} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    h1x_q, h1x_d, h2x_q, h2x_d;
  logic [6:0]    h1y_q, h1y_d, h2y_q, h2y_d;
  logic [5:0]    size_1_q, size_1_d, size_2_q, size_2_d;
  logic          wall_1_q, wall_1_d, self_1_q, self_1_d, other_1_q, other_1_d;
  logic          wall_2_q, wall_2_d, self_2_q, self_2_d, other_2_q, other_2_d;
  logic [1:0]    cause_1_q, cause_1_d, cause_2_q, cause_2_d;

  logic          in_1, in_2;
  logic [7:0]    seg_1_x, seg_2_x;
  logic [6:0]    seg_1_y, seg_2_y;

  function automatic logic is_wall(input logic [7:0] x, input logic [6:0] y);
    // Underflowed coordinates (255 / 127) fall into the >= tests and count as wall.
    return (x == 8'd0) || (int'(x) >= GRID_W - 1) ||
           (y == 7'd0) || (int'(y) >= GRID_H - 1);
  endfunction

  function automatic logic [1:0] pick_cause(input logic w, input logic s, input logic o);
    if (w)      return CAUSE_WALL;
    else if (s) return CAUSE_SELF;
    else if (o) return CAUSE_OTHER;
    else        return CAUSE_NONE;
  endfunction

  assign in_1    = 32'(idx_q) < 32'(size_1_q);
  assign in_2    = 32'(idx_q) < 32'(size_2_q);
  assign seg_1_x = snake_1_x[idx_q];
  assign seg_1_y = snake_1_y[idx_q];
  assign seg_2_x = snake_2_x[idx_q];
  assign seg_2_y = snake_2_y[idx_q];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    h1x_d     = h1x_q;
    h1y_d     = h1y_q;
    h2x_d     = h2x_q;
    h2y_d     = h2y_q;
    size_1_d  = size_1_q;
    size_2_d  = size_2_q;
    wall_1_d  = wall_1_q;
    self_1_d  = self_1_q;
    other_1_d = other_1_q;
    wall_2_d  = wall_2_q;
    self_2_d  = self_2_q;
    other_2_d = other_2_q;
    cause_1_d = cause_1_q;
    cause_2_d = cause_2_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          h1x_d     = snake_1_x[0];
          h1y_d     = snake_1_y[0];
          h2x_d     = snake_2_x[0];
          h2y_d     = snake_2_y[0];
          size_1_d  = snake_1_size;
          size_2_d  = snake_2_size;
          wall_1_d  = is_wall(snake_1_x[0], snake_1_y[0]);
          wall_2_d  = is_wall(snake_2_x[0], snake_2_y[0]);
          self_1_d  = 1'b0;
          self_2_d  = 1'b0;
          other_1_d = (snake_1_x[0] == snake_2_x[0]) && (snake_1_y[0] == snake_2_y[0]);
          other_2_d = other_1_d;
          cause_1_d = CAUSE_NONE;
          cause_2_d = CAUSE_NONE;
          idx_d     = IW'(1);
          state_d   = S_SCAN;
        end
      end
      S_SCAN: begin
        if (in_1 && seg_1_x == h1x_q && seg_1_y == h1y_q) self_1_d  = 1'b1;
        if (in_1 && seg_1_x == h2x_q && seg_1_y == h2y_q) other_2_d = 1'b1;
        if (in_2 && seg_2_x == h2x_q && seg_2_y == h2y_q) self_2_d  = 1'b1;
        if (in_2 && seg_2_x == h1x_q && seg_2_y == h1y_q) other_1_d = 1'b1;
        // Causes latch on the REPORT transition so they are valid alongside done.
        if (idx_q == LAST_IDX) begin
          cause_1_d = pick_cause(wall_1_d, self_1_d, other_1_d);
          cause_2_d = pick_cause(wall_2_d, self_2_d, other_2_d);
          state_d   = S_REPORT;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_REPORT: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      h1x_q     <= '0;
      h1y_q     <= '0;
      h2x_q     <= '0;
      h2y_q     <= '0;
      size_1_q  <= '0;
      size_2_q  <= '0;
      wall_1_q  <= 1'b0;
      self_1_q  <= 1'b0;
      other_1_q <= 1'b0;
      wall_2_q  <= 1'b0;
      self_2_q  <= 1'b0;
      other_2_q <= 1'b0;
      cause_1_q <= CAUSE_NONE;
      cause_2_q <= CAUSE_NONE;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      h1x_q     <= h1x_d;
      h1y_q     <= h1y_d;
      h2x_q     <= h2x_d;
      h2y_q     <= h2y_d;
      size_1_q  <= size_1_d;
      size_2_q  <= size_2_d;
      wall_1_q  <= wall_1_d;
      self_1_q  <= self_1_d;
      other_1_q <= other_1_d;
      wall_2_q  <= wall_2_d;
      self_2_q  <= self_2_d;
      other_2_q <= other_2_d;
      cause_1_q <= cause_1_d;
      cause_2_q <= cause_2_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_REPORT);
  assign respawn_1 = done && (wall_1_q || self_1_q || other_1_q);
  assign respawn_2 = done && (wall_2_q || self_2_q || other_2_q);
  assign cause_1   = cause_1_q;
  assign cause_2   = cause_2_q;

endmodule

// File: tb/tb_snake_collision_checker.sv
// Directed bench for snake_collision_checker: a geometric model plus a per-cycle output timeline, and literal checks per scenario.
module tb_snake_collision_checker;

  localparam int ML = 64;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [7:0] s1x [ML-1:0];
  logic [6:0] s1y [ML-1:0];
  logic [7:0] s2x [ML-1:0];
  logic [6:0] s2y [ML-1:0];
  logic [5:0] sz1, sz2;
  logic       busy, done, respawn_1, respawn_2;
  logic [1:0] cause_1, cause_2;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit chk_en = 0;
  bit m_act  = 0;
  int m_t0   = 0;
  logic [1:0] p1 = 2'd0, p2 = 2'd0;

  snake_collision_checker #(.GRID_W(160), .GRID_H(120), .MAX_LEN(ML)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .snake_1_x(s1x), .snake_1_y(s1y), .snake_2_x(s2x), .snake_2_y(s2y),
    .snake_1_size(sz1), .snake_2_size(sz2),
    .busy(busy), .done(done), .respawn_1(respawn_1), .respawn_2(respawn_2),
    .cause_1(cause_1), .cause_2(cause_2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bit wall(input int x, input int y);
    return x == 0 || x >= 159 || y == 0 || y >= 119;
  endfunction

  // Geometric model: what each snake hit, resolved by priority wall > self > other.
  function automatic logic [3:0] expect_causes();
    bit w1, w2, sf1, sf2, o1, o2;
    logic [1:0] c1, c2;
    w1 = wall(s1x[0], s1y[0]);
    w2 = wall(s2x[0], s2y[0]);
    sf1 = 0; sf2 = 0;
    o1 = (s1x[0] == s2x[0]) && (s1y[0] == s2y[0]);
    o2 = o1;
    for (int i = 1; i < int'(sz1); i++) begin
      if (s1x[i] == s1x[0] && s1y[i] == s1y[0]) sf1 = 1;
      if (s1x[i] == s2x[0] && s1y[i] == s2y[0]) o2 = 1;
    end
    for (int i = 1; i < int'(sz2); i++) begin
      if (s2x[i] == s2x[0] && s2y[i] == s2y[0]) sf2 = 1;
      if (s2x[i] == s1x[0] && s2y[i] == s1y[0]) o1 = 1;
    end
    c1 = w1 ? 2'd1 : sf1 ? 2'd2 : o1 ? 2'd3 : 2'd0;
    c2 = w2 ? 2'd1 : sf2 ? 2'd2 : o2 ? 2'd3 : 2'd0;
    return {c1, c2};
  endfunction

  // Timeline: a start accepted at edge t0 keeps busy through edge t0+63's cycle, done in that cycle.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_act = 0;
    end else begin
      cyc++;
      if (start && (!m_act || cyc > m_t0 + ML)) begin
        m_act = 1;
        m_t0  = cyc;
        {p1, p2} = expect_causes();
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic eb, ed;
      logic [1:0] ec1, ec2;
      eb  = m_act && (cyc - m_t0 <= ML - 1);
      ed  = m_act && (cyc == m_t0 + ML - 1);
      ec1 = (m_act && cyc >= m_t0 + ML - 1) ? p1 : 2'd0;
      ec2 = (m_act && cyc >= m_t0 + ML - 1) ? p2 : 2'd0;
      check("cycle_outputs {busy,done,r1,r2,c1,c2}",
            32'({busy, done, respawn_1, respawn_2, cause_1, cause_2}),
            32'({eb, ed, ed && ec1 != 0, ed && ec2 != 0, ec1, ec2}));
    end
  end

  task automatic set_snake(input int n, input int hx, input int hy, input int dx, input int dy, input int sz);
    for (int i = 0; i < ML; i++) begin
      if (n == 1) begin
        s1x[i] = (i < sz) ? 8'(hx - dx * i) : 8'd0;
        s1y[i] = (i < sz) ? 7'(hy - dy * i) : 7'd0;
      end else begin
        s2x[i] = (i < sz) ? 8'(hx - dx * i) : 8'd0;
        s2y[i] = (i < sz) ? 7'(hy - dy * i) : 7'd0;
      end
    end
    if (n == 1) sz1 = 6'(sz);
    else        sz2 = 6'(sz);
  endtask

  // Pulse start (driven just after a falling edge) and count falling edges until done.
  task automatic pulse_wait(output int lat);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    if (!done) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", lat);
    end
  endtask

  task automatic run(input string name, input logic [1:0] c1, input logic [1:0] c2);
    int lat;
    pulse_wait(lat);
    check({name, "_latency"}, lat, ML);
    check({name, "_cause1"}, cause_1, c1);
    check({name, "_cause2"}, cause_2, c2);
    check({name, "_respawn"}, {respawn_1, respawn_2}, {c1 != 0, c2 != 0});
    @(negedge clk); #1;
  endtask

  initial begin
    int lat, nd;
    resetn = 1'b0;
    start  = 1'b0;
    set_snake(1, 0, 0, 0, 0, 0);
    set_snake(2, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk_en = 1;
    check("reset_outputs", {busy, done, respawn_1, respawn_2, cause_1, cause_2}, 8'd0);
    @(negedge clk); #1 resetn = 1'b1;
    @(negedge clk); #1;

    // No collision
    set_snake(1, 20, 15, 1, 0, 5);
    set_snake(2, 139, 104, -1, 0, 5);
    run("no_collision", 2'd0, 2'd0);

    // Wall, including an underflowed y
    set_snake(1, 0, 15, -1, 0, 5);
    run("wall_x0", 2'd1, 2'd0);
    set_snake(1, 20, 127, 1, 0, 5);
    run("wall_y127", 2'd1, 2'd0);

    // Self-hit inside size, and the same match hidden beyond size
    set_snake(1, 50, 50, 1, 0, 5);
    s1x[3] = 8'd50; s1y[3] = 7'd50;
    run("self_hit", 2'd2, 2'd0);
    set_snake(1, 50, 50, 1, 0, 5);
    s1x[6] = 8'd50; s1y[6] = 7'd50;
    run("self_masked", 2'd0, 2'd0);

    // Size 1 and size 0: no body compares, wall still applies
    set_snake(1, 50, 50, 1, 0, 1);
    s1x[1] = 8'd50; s1y[1] = 7'd50;
    run("size1_no_self", 2'd0, 2'd0);
    set_snake(1, 0, 10, -1, 0, 0);
    run("size0_wall", 2'd1, 2'd0);

    // Last index inside size counts; last index outside size does not
    set_snake(1, 100, 60, 1, 0, 63);
    s1x[62] = 8'd100; s1y[62] = 7'd60;
    run("self_idx62", 2'd2, 2'd0);
    set_snake(1, 100, 60, 1, 0, 63);
    s1x[63] = 8'd100; s1y[63] = 7'd60;
    run("masked_idx63", 2'd0, 2'd0);

    // Other body, then head-to-head
    set_snake(2, 60, 30, 1, 0, 4);
    set_snake(1, 58, 30, 0, -1, 3);
    run("other_body", 2'd3, 2'd0);
    set_snake(1, 80, 60, 1, 0, 5);
    set_snake(2, 80, 60, -1, 0, 5);
    run("head_to_head", 2'd3, 2'd3);

    // Wall beats self
    set_snake(2, 139, 104, -1, 0, 5);
    set_snake(1, 0, 20, 0, 1, 5);
    s1x[2] = 8'd0; s1y[2] = 7'd20;
    run("wall_over_self", 2'd1, 2'd0);

    // Second start at +10 ignored
    set_snake(1, 20, 15, 1, 0, 5);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(negedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    nd = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("second_start_ignored_done_count", nd, 1);

    // Reset at +30 aborts with no done
    set_snake(1, 0, 15, -1, 0, 5);
    @(negedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (30) @(negedge clk);
    #1 resetn = 1'b0;
    #1 check("reset_midscan_outputs", {busy, done, respawn_1, respawn_2, cause_1, cause_2}, 8'd0);
    @(negedge clk); #1 resetn = 1'b1;
    nd = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("reset_abort_no_done", nd, 0);

    // Start held through REPORT: ignored there, accepted the cycle after
    #1;
    set_snake(1, 20, 15, 1, 0, 5);
    pulse_wait(lat);
    check("pre_restart_latency", lat, ML);
    #1 start = 1'b1;
    @(negedge clk);
    check("start_in_report_ignored", busy, 1'b0);
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    check("restart_accepted_latency", lat, ML);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
